snake_move: RTL
===============

# snake_move

Movement engine sitting directly downstream of the direction generator. It consumes the debounced one-hot `direction` word and advances the snake one grid cell per step tick. It keeps the body as a shift buffer of segment coordinates and detects wall and self collisions and food consumption. It also exposes a per-pixel occupancy query for the VGA renderer.

## Interface
- `GRID_W`, default 40: grid columns; x range 0..GRID_W-1
- `GRID_H`, default 30: grid rows; y range 0..GRID_H-1
- `MAX_LEN`, default 16: segment buffer depth, at most 31
- `INIT_LEN`, default 3: length after reset/restart; must be ≥2 and ≤MAX_LEN
- `STEP_CYCLES`, default 12_500_000: clocks per step; 4 steps/s at 50 MHz
- `clk` in 1: system clock, the single clock domain
- `rst_n` in 1: reset; synchronous, active-low
- `direction` in 4: one-hot; bit3 up (y-1), bit2 down (y+1), bit1 left (x-1), bit0 right (x+1)
- `food_x` in 6, `food_y` in 5: current food cell
- `restart` in 1: synchronous pulse; same effect as reset
- `q_x` in 6, `q_y` in 5: occupancy query cell from the renderer
- `q_hit` out 1: combinational; query cell equals an active segment
- `q_head` out 1: combinational; query cell equals the head
- `head_x` out 6, `head_y` out 5: segment 0
- `length` out 5: active segment count
- `step` out 1: one-cycle pulse when the body moved
- `ate` out 1: one-cycle pulse, coincident with `step`, when food was eaten
- `game_over` out 1: sticky until reset or restart

## Operation
- States:
  - PLAY: step counter runs.
  - OVER: counter is held at 0, segments are frozen, `game_over`=1.
- Reset or restart values:
  - State is PLAY, counter is 0, `length`=INIT_LEN.
  - Segment i = (GRID_W/2, GRID_H/2 − i), giving a head at (20,15) by default and the body above it.
  - Applied direction is down (4'b0100).
  - `step`, `ate` and `game_over` are all 0.
- Counter counts 0..STEP_CYCLES-1 and wraps. The terminal cycle is the step cycle.
- On the step cycle, `direction` is sampled:
  - Non-one-hot values (including 0000) leave the applied direction unchanged.
  - A direct reversal of the applied direction is ignored.
  - Otherwise the sampled value becomes the applied direction.
- The next head is the current head moved one cell in the applied direction.
- Wall collision: the next head would leave 0..GRID_W-1 or 0..GRID_H-1. Detection uses the pre-move coordinate at the edge, so there is no arithmetic underflow.
- Food: eat = (next head == food).
- Self collision: the next head equals any active segment 0..length-1.
  - Exception: the tail segment is excluded when not eating, because it vacates this step.
  - When eating, the tail segment is included.
- On any collision:
  - Go to OVER with no segment update.
  - `step` and `ate` stay 0.
- With no collision:
  - seg[i] ← seg[i-1] for i≥1, and seg[0] ← next head.
  - If eating and length<MAX_LEN: length+1 and `ate`=1.
  - If eating at MAX_LEN: length stays, `ate`=1.
- Segments with index ≥ length are inactive and are ignored by `q_hit` and by collision checks.
- `restart` takes priority over a step in the same cycle.

## Timing
- Step cycle → segment registers, `length`, `step`, `ate` and `game_over` all update on the same edge.
- New values are visible in the cycle after the terminal count. `step`/`ate` are high for exactly that cycle.
- `direction` needs to be stable only on the terminal-count cycle. A direction change takes effect at the next step (latency up to STEP_CYCLES).
- `q_hit`/`q_head` are purely combinational from `q_x/q_y` and the segment registers (no latency). They reflect the updated body from the cycle after the step.
- `rst_n` low or `restart` high mid-step: all state reinitialises on that edge; no partial update.

## Test plan
Benches use STEP_CYCLES=4 and defaults otherwise.

- **Reset then idle, direction=0100, food (0,0):** head goes (20,15)→(20,16)→(20,17) every 4 clocks. `step` is high exactly 1 cycle per 4; `length`=3; `q_hit` is 1 at (20,15) after the first step and 0 at (20,13).
- **Direction 1000 (up reversal) at the step cycle, then 0001:** the reversal is ignored and the snake continues down; the next step moves to x+1. Direction 0000 or 0110 keeps the current heading.
- **Food placed at (20,16) before the first step:** `ate`=1 together with `step`, `length`=4, and the tail cell (20,13) remains occupied. Filling to MAX_LEN: `length` saturates at 16 and `ate` still pulses.
- **Heading right from x=39:** the next step asserts `game_over`; the head stays at x=39 with no `step` pulse; the counter and segments stay frozen for 20 further cycles.
- **Self collision, length 5, tracing down, right, up, left:** `game_over`=1. Moving into the vacating tail cell with length 4 (tight square loop) must NOT end the game.
- **`restart` pulse while in OVER and coincident with a step cycle:** state returns to the reset values on the next edge, `game_over`=0, and the first step follows 4 clocks later.

Source files
------------

// File: rtl/snake_move.sv
// snake_move: grid snake movement engine with wall/self collision, food and occupancy query
`timescale 1ns/100ps
module snake_move #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int MAX_LEN = 16,
  parameter int INIT_LEN = 3,
  parameter int STEP_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] direction,
  input  logic [5:0] food_x,
  input  logic [4:0] food_y,
  input  logic       restart,
  input  logic [5:0] q_x,
  input  logic [4:0] q_y,
  output logic       q_hit,
  output logic       q_head,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length,
  output logic       step,
  output logic       ate,
  output logic       game_over
);
  localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  typedef enum logic {PLAY, OVER} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] dir, dir_nx;
  logic [5:0] seg_x [MAX_LEN];
  logic [4:0] seg_y [MAX_LEN];
  logic [5:0] nx;
  logic [4:0] ny;
  logic init, tick, rev, wall, eat, self_hit, collide;
  assign init = !rst_n || restart;
  assign tick = state == PLAY && cnt == CW'(STEP_CYCLES - 1);
  assign rev = direction == {dir[2], dir[3], dir[0], dir[1]};
  assign dir_nx = $onehot(direction) && !rev ? direction : dir;
  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign nx = dir_nx[0] ? head_x + 6'd1 : dir_nx[1] ? head_x - 6'd1 : head_x;
  assign ny = dir_nx[2] ? head_y + 5'd1 : dir_nx[3] ? head_y - 5'd1 : head_y;
  // edge tests use the pre-move coordinate so nothing wraps
  assign wall = (dir_nx[0] && head_x == 6'(GRID_W - 1)) || (dir_nx[1] && head_x == 6'd0) ||
                (dir_nx[2] && head_y == 5'(GRID_H - 1)) || (dir_nx[3] && head_y == 5'd0);
  assign eat = nx == food_x && ny == food_y;
  assign collide = wall || self_hit;
  assign game_over = state == OVER;
  assign q_head = q_x == head_x && q_y == head_y;
  always_comb begin
    self_hit = 1'b0;
    q_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (5'(i) < length && (eat || 5'(i) != length - 5'd1) && seg_x[i] == nx && seg_y[i] == ny) self_hit = 1'b1;
      if (5'(i) < length && seg_x[i] == q_x && seg_y[i] == q_y) q_hit = 1'b1;
    end
  end
  always_comb state_nx = tick && collide ? OVER : state;
  always_ff @(posedge clk) state <= init ? PLAY : state_nx;
  always_ff @(posedge clk) begin
    if (init) begin
      cnt <= '0;
      dir <= 4'b0100;
      length <= 5'(INIT_LEN);
      step <= 1'b0;
      ate <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(GRID_W / 2);
        seg_y[i] <= 5'(GRID_H / 2 - i);
      end
    end else begin
      cnt <= state == OVER || tick ? '0 : cnt + CW'(1);
      step <= tick && !collide;
      ate <= tick && !collide && eat;
      if (tick) dir <= dir_nx;
      if (tick && !collide) begin
        seg_x[0] <= nx;
        seg_y[0] <= ny;
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        if (eat && length < 5'(MAX_LEN)) length <= length + 5'd1;
      end
    end
  end
endmodule
